mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 156 +++++++++++++++
 tb/tb_mem_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch and data side; data wins unless fetch starved.
// Grant on the decision edge, rvld the cycle after i_mem_rdy; unserved requesters hold req (o_arb_hold stalls data).
module mem_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvld,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic        i_d_lock,
  output logic        o_d_gnt,
  output logic        o_d_rvld,
  output logic [31:0] o_rdata,
  output logic        o_arb_hold,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rdy,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_BUSY = 2'd1, D_BUSY = 2'd2, D_LOCK = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [1:0]  starve_q, starve_d;
  logic        lock_q, lock_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        if_gnt_q, if_gnt_d;
  logic        d_gnt_q, d_gnt_d;
  logic        if_rvld_q, if_rvld_d;
  logic        d_rvld_q, d_rvld_d;
  logic        fetch_wins, take_if, take_d;
  logic        unused_addr_bits;

  // Fetch only beats a concurrent data request once it has lost three decisions in a row.
  assign fetch_wins       = i_if_req & (~i_d_req | (starve_q == 2'd3));
  assign unused_addr_bits = ^i_if_addr[1:0];

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    lock_d      = lock_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvld_d   = 1'b0;
    d_rvld_d    = 1'b0;
    take_if     = 1'b0;
    take_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (fetch_wins) take_if = 1'b1;
          else            take_d  = i_d_req;
        end
      end
      D_LOCK: take_d = en & i_d_req;
      IF_BUSY: begin
        if (i_mem_rdy) begin
          mem_req_d = 1'b0;
          rdata_d   = i_mem_rdata;
          if_rvld_d = 1'b1;
          state_d   = IDLE;
        end
      end
      D_BUSY: begin
        if (i_mem_rdy) begin
          mem_req_d = 1'b0;
          rdata_d   = i_mem_rdata;
          d_rvld_d  = 1'b1;
          state_d   = lock_q ? D_LOCK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_if) begin
      state_d     = IF_BUSY;
      lock_d      = i_d_lock;
      starve_d    = 2'd0;
      if_gnt_d    = 1'b1;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = {i_if_addr[31:2], 2'b00};
      mem_wdata_d = 32'd0;
    end
    if (take_d) begin
      state_d     = D_BUSY;
      lock_d      = i_d_lock;
      d_gnt_d     = 1'b1;
      mem_req_d   = 1'b1;
      mem_we_d    = i_d_we;
      mem_addr_d  = i_d_addr;
      mem_wdata_d = i_d_wdata;
      // Only an IDLE decision that passes over a waiting fetch counts as starvation.
      if ((state_q == IDLE) && i_if_req && (starve_q != 2'd3)) starve_d = starve_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= 2'd0;
      lock_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvld_q   <= 1'b0;
      d_rvld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      lock_q      <= lock_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvld_q   <= if_rvld_d;
      d_rvld_q    <= d_rvld_d;
    end
  end

  assign o_arb_hold  = i_d_req & ((state_q == IF_BUSY) | (state_q == D_BUSY) |
                                  ((state_q == IDLE) & fetch_wins) | ~en);
  assign o_if_gnt    = if_gnt_q;
  assign o_d_gnt     = d_gnt_q;
  assign o_if_rvld   = if_rvld_q;
  assign o_d_rvld    = d_rvld_q;
  assign o_rdata     = rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of bus ownership.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = 32'd0;
  logic        i_d_req = 1'b0;
  logic        i_d_we = 1'b0;
  logic [31:0] i_d_addr = 32'd0;
  logic [31:0] i_d_wdata = 32'd0;
  logic        i_d_lock = 1'b0;
  logic        i_mem_rdy = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;
  logic        o_if_gnt, o_if_rvld, o_d_gnt, o_d_rvld, o_arb_hold;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt), .o_if_rvld(o_if_rvld),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .i_d_lock(i_d_lock), .o_d_gnt(o_d_gnt), .o_d_rvld(o_d_rvld), .o_rdata(o_rdata),
    .o_arb_hold(o_arb_hold), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdy(i_mem_rdy), .i_mem_rdata(i_mem_rdata)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: who owns the bus, and what it must show ----------------
  localparam logic [1:0] OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2;

  typedef struct packed {
    logic [1:0]  owner;
    logic        cur_lock;
    logic        held;
    logic [1:0]  starve;
    logic        if_gnt, d_gnt, if_rvld, d_rvld, mem_req, mem_we;
    logic [31:0] addr, wdata, rdata;
  } m_t;

  m_t m = '0;

  function automatic m_t step(input m_t s);
    m_t  n;
    logic to_if, to_d;
    n = s;
    n.if_gnt = 1'b0; n.d_gnt = 1'b0; n.if_rvld = 1'b0; n.d_rvld = 1'b0;
    to_if = 1'b0; to_d = 1'b0;
    if (s.owner != OWN_NONE) begin
      if (i_mem_rdy) begin
        n.mem_req = 1'b0;
        n.rdata   = i_mem_rdata;
        if (s.owner == OWN_IF) n.if_rvld = 1'b1;
        else begin
          n.d_rvld = 1'b1;
          n.held   = s.cur_lock;
        end
        n.owner = OWN_NONE;
      end
    end else if (en) begin
      if (s.held)                                      to_d  = i_d_req;
      else if (i_if_req && (!i_d_req || s.starve == 2'd3)) to_if = 1'b1;
      else                                             to_d  = i_d_req;
      if (to_if) begin
        n.owner = OWN_IF; n.cur_lock = i_d_lock; n.starve = 2'd0; n.if_gnt = 1'b1;
        n.mem_req = 1'b1; n.mem_we = 1'b0; n.addr = i_if_addr & 32'hFFFF_FFFC; n.wdata = 32'd0;
      end
      if (to_d) begin
        n.owner = OWN_D; n.cur_lock = i_d_lock; n.d_gnt = 1'b1;
        n.mem_req = 1'b1; n.mem_we = i_d_we; n.addr = i_d_addr; n.wdata = i_d_wdata;
        if (!s.held && i_if_req) n.starve = (s.starve == 2'd3) ? 2'd3 : s.starve + 2'd1;
      end
    end
    return n;
  endfunction

  function automatic logic exp_hold();
    return i_d_req & ((m.owner != OWN_NONE) |
                      ((m.owner == OWN_NONE) & !m.held & i_if_req & (m.starve == 2'd3)) | !en);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m);
  end

  logic cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("ctl{ifg,ifv,dg,dv,hold,req,we}",
          {25'd0, o_if_gnt, o_if_rvld, o_d_gnt, o_d_rvld, o_arb_hold, o_mem_req, o_mem_we},
          {25'd0, m.if_gnt, m.if_rvld, m.d_gnt, m.d_rvld, exp_hold(), m.mem_req, m.mem_we});
      chk("mem_addr", o_mem_addr, m.addr);
      chk("mem_wdata", o_mem_wdata, m.wdata);
      chk("rdata", o_rdata, m.rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    en = 1'b1; i_if_req = 1'b0; i_if_addr = 32'd0; i_d_req = 1'b0; i_d_we = 1'b0;
    i_d_addr = 32'd0; i_d_wdata = 32'd0; i_d_lock = 1'b0; i_mem_rdy = 1'b0; i_mem_rdata = 32'd0;
  endtask

  task automatic rand_inputs();
    en = 1'($urandom_range(0, 1)); i_if_req = 1'($urandom_range(0, 1)); i_if_addr = $urandom;
    i_d_req = 1'($urandom_range(0, 1)); i_d_we = 1'($urandom_range(0, 1)); i_d_addr = $urandom;
    i_d_wdata = $urandom; i_d_lock = 1'($urandom_range(0, 1));
    i_mem_rdy = 1'($urandom_range(0, 1)); i_mem_rdata = $urandom;
  endtask

  bit exp_if [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int   k;
    logic hold_b;

    // Reset held with random inputs: every registered output stays zero.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      tick();
      cmp_on = 1'b1;
      chk("reset_ctl", {26'd0, o_if_gnt, o_if_rvld, o_d_gnt, o_d_rvld, o_mem_req, o_mem_we}, 32'd0);
      chk("reset_data", o_mem_addr | o_mem_wdata | o_rdata, 32'd0);
    end
    quiet_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("idle_no_req", o_mem_req, 1'b0);
    end

    // Single fetch with one wait cycle.
    i_if_req = 1'b1; i_if_addr = 32'h0000_1003;
    tick();
    chk1("fetch_gnt", o_if_gnt, 1'b1);
    chk("fetch_addr_aligned", o_mem_addr, 32'h0000_1000);
    chk1("fetch_we", o_mem_we, 1'b0);
    i_if_req = 1'b0;
    tick();
    chk1("fetch_gnt_pulse", o_if_gnt, 1'b0);
    chk1("fetch_req_stable", o_mem_req, 1'b1);
    i_mem_rdy = 1'b1; i_mem_rdata = 32'hE1A0_0000;
    tick();
    chk1("fetch_rvld", o_if_rvld, 1'b1);
    chk("fetch_rdata", o_rdata, 32'hE1A0_0000);
    chk1("fetch_req_clear", o_mem_req, 1'b0);
    i_mem_rdy = 1'b0; i_mem_rdata = 32'h1234_5678;
    tick();
    chk1("fetch_rvld_pulse", o_if_rvld, 1'b0);
    chk("rdata_hold", o_rdata, 32'hE1A0_0000);

    // Both requesting continuously, zero-wait memory: starvation breaks every fourth grant.
    i_if_req = 1'b1; i_if_addr = 32'h0000_2000; i_d_req = 1'b1; i_d_addr = 32'h0000_3000;
    i_mem_rdy = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      hold_b = o_arb_hold;
      tick();
      if (o_if_gnt || o_d_gnt) begin
        chk1("order_is_fetch", o_if_gnt, exp_if[k]);
        chk1("hold_on_decision", hold_b, exp_if[k]);
        k++;
      end
    end
    chk("order_count", k, 32'd8);
    i_if_req = 1'b0; i_d_req = 1'b0;
    tick();
    i_mem_rdy = 1'b0;
    tick();

    // SWP: locked read keeps the bus for the following write.
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_lock = 1'b1; i_d_addr = 32'h0000_0200;
    tick();
    chk1("swp_rd_gnt", o_d_gnt, 1'b1);
    i_d_req = 1'b0; i_d_lock = 1'b0; i_mem_rdy = 1'b1; i_mem_rdata = 32'h0000_0055;
    tick();
    chk1("swp_rd_rvld", o_d_rvld, 1'b1);
    chk("swp_rd_data", o_rdata, 32'h0000_0055);
    i_mem_rdy = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h0000_0400;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("swp_no_fetch_locked", o_if_gnt, 1'b0);
    end
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_wdata = 32'h0000_ABCD;
    tick();
    chk1("swp_wr_gnt", o_d_gnt, 1'b1);
    chk1("swp_wr_no_fetch", o_if_gnt, 1'b0);
    chk1("swp_wr_we", o_mem_we, 1'b1);
    i_d_req = 1'b0; i_d_we = 1'b0; i_mem_rdy = 1'b1;
    tick();
    chk1("swp_wr_rvld", o_d_rvld, 1'b1);
    chk1("swp_wr_no_fetch2", o_if_gnt, 1'b0);
    i_mem_rdy = 1'b0;
    tick();
    chk1("swp_fetch_after", o_if_gnt, 1'b1);
    i_if_req = 1'b0; i_mem_rdy = 1'b1;
    tick();
    i_mem_rdy = 1'b0;
    tick();

    // Reset mid data access: access abandoned, next request served normally.
    i_d_req = 1'b1; i_d_addr = 32'h0000_0600;
    tick();
    chk1("rst_d_gnt", o_d_gnt, 1'b1);
    i_d_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 chk1("rst_async_req_drop", o_mem_req, 1'b0);
    i_mem_rdy = 1'b1;
    tick();
    chk1("rst_no_rvld", o_d_rvld, 1'b0);
    i_mem_rdy = 1'b0; rst_n = 1'b1; i_d_req = 1'b1; i_d_addr = 32'h0000_0700;
    tick();
    chk1("rst_fresh_gnt", o_d_gnt, 1'b1);
    chk("rst_fresh_addr", o_mem_addr, 32'h0000_0700);
    i_d_req = 1'b0; i_mem_rdy = 1'b1;
    tick();
    chk1("rst_fresh_rvld", o_d_rvld, 1'b1);
    i_mem_rdy = 1'b0;
    tick();

    // en=0 during an in-flight fetch with a data request pending.
    i_if_req = 1'b1; i_if_addr = 32'h0000_0800;
    tick();
    chk1("en_fetch_gnt", o_if_gnt, 1'b1);
    i_if_req = 1'b0; en = 1'b0; i_d_req = 1'b1; i_d_addr = 32'h0000_0900;
    tick();
    chk1("en_hold_busy", o_arb_hold, 1'b1);
    i_mem_rdy = 1'b1;
    tick();
    chk1("en_fetch_rvld", o_if_rvld, 1'b1);
    i_mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("en_off_no_dgnt", o_d_gnt, 1'b0);
      chk1("en_off_hold", o_arb_hold, 1'b1);
    end
    en = 1'b1;
    tick();
    chk1("en_on_dgnt", o_d_gnt, 1'b1);
    i_d_req = 1'b0; i_mem_rdy = 1'b1;
    tick();
    i_mem_rdy = 1'b0;
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (o_if_gnt) i_if_req = 1'b0;
      else if (!i_if_req && $urandom_range(0, 3) == 0) begin
        i_if_req = 1'b1; i_if_addr = $urandom;
      end else if (i_if_req && $urandom_range(0, 40) == 0) i_if_req = 1'b0;
      if (o_d_gnt) i_d_req = 1'b0;
      else if (!i_d_req && $urandom_range(0, 2) == 0) begin
        i_d_req = 1'b1; i_d_we = 1'($urandom_range(0, 1)); i_d_addr = $urandom;
        i_d_wdata = $urandom; i_d_lock = ($urandom_range(0, 3) == 0);
      end else if (i_d_req && $urandom_range(0, 40) == 0) i_d_req = 1'b0;
      en          = ($urandom_range(0, 9) != 0);
      i_mem_rdy   = ($urandom_range(0, 2) == 0);
      i_mem_rdata = $urandom;
      rst_n       = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
